// File: rtl/alu_seq.sv
// Handshaked, parametrised ALU: eight single-cycle operations plus iterative
// one-bit-per-cycle shifts; results are registered and held until consumed.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [3:0]       command,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int SHW = $clog2(WIDTH);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready high
    // SHIFT | shifting result register one bit per cycle
    // DONE  | result valid, held until out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q;
    logic [SHW-1:0]   cnt;
    logic [1:0]       shop;

    logic             is_shift, start_shift, accept, sub_sel, slt;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] b_x, alu_res, shift_nxt;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v;

    assign is_shift    = command[3] && (command[2:0] < 3'd3);
    assign amt         = operandB[SHW-1:0];
    assign start_shift = is_shift && (amt != '0);
    assign accept      = in_valid && (state == IDLE);
    assign sub_sel     = (command == 4'b0001);
    assign slt         = $signed(operandA) < $signed(operandB);

    always_comb begin
        b_x     = sub_sel ? ~operandB : operandB;
        sum     = {1'b0, operandA} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub_sel};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (command)
            4'b0000, 4'b0001: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (operandA[WIDTH-1] == b_x[WIDTH-1]) &&
                          (sum[WIDTH-1] != operandA[WIDTH-1]);
            end
            4'b0010: alu_res = operandA ^ operandB;
            4'b0011: alu_res = {{(WIDTH-1){1'b0}}, slt};
            4'b0100: alu_res = operandA & operandB;
            4'b0101: alu_res = ~(operandA & operandB);
            4'b0110: alu_res = ~(operandA | operandB);
            4'b0111: alu_res = operandA | operandB;
            // only reached as a single-cycle op when the shift amount is zero
            4'b1000, 4'b1001, 4'b1010: alu_res = operandA;
            default: alu_res = '0;
        endcase
    end

    // SRA replicates the current MSB, which is always the original sign bit
    always_comb begin
        case (shop)
            2'b00:   shift_nxt = {result_q[WIDTH-2:0], 1'b0};
            2'b01:   shift_nxt = {1'b0, result_q[WIDTH-1:1]};
            default: shift_nxt = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = start_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == SHW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
            shop     <= 2'b00;
        end else if (accept) begin
            if (start_shift) begin
                result_q <= operandA;
                carry_q  <= 1'b0;
                ovf_q    <= 1'b0;
                cnt      <= amt;
                shop     <= command[1:0];
            end else begin
                result_q <= alu_res;
                carry_q  <= alu_c;
                ovf_q    <= alu_v;
            end
        end else if (state == SHIFT) begin
            result_q <= shift_nxt;
            cnt      <= cnt - SHW'(1);
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
    assign zero      = ~|result_q;
endmodule
